// File: rtl/rv_decode_stage.sv
// RV32I decode stage: classifies raw instruction words, extracts fields and a sign-extended
// immediate, and buffers results in a 2-entry output/skid buffer behind valid/ready handshakes.
module rv_decode_stage #(
    parameter int CNT_W        = 16,
    parameter bit ILLEGAL_PASS = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_type,
    output logic [6:0]       out_opcode,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [31:0]      out_imm,
    output logic             out_rd_we,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] accept_count,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [2:0] {
        T_R   = 3'd0,
        T_I   = 3'd1,
        T_S   = 3'd2,
        T_B   = 3'd3,
        T_U   = 3'd4,
        T_J   = 3'd5,
        T_ILL = 3'd7
    } itype_e;

    // Raw fields are recovered from the stored word, so only derived values are kept alongside it.
    typedef struct packed {
        itype_e      typ;
        logic [31:0] imm;
        logic        rd_we;
        logic [31:0] instr;
    } dec_t;

    dec_t             w_dec;
    dec_t             w_out_nxt;
    dec_t             w_skid_nxt;
    logic             w_out_valid_nxt;
    logic             w_skid_valid_nxt;
    logic             w_accept;
    logic             w_illegal;
    logic             w_load;

    dec_t             r_out;
    dec_t             r_skid;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_accept_count;
    logic [CNT_W-1:0] r_illegal_count;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_dec       = '0;
        w_dec.instr = in_instr;
        case (in_instr[6:0])
            7'b0110011: w_dec.typ = T_R;
            7'b0010011: begin
                w_dec.typ = T_I;
                w_dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                w_dec.typ = T_S;
                w_dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                w_dec.typ = T_B;
                w_dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0010111: begin
                w_dec.typ = T_U;
                w_dec.imm = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                w_dec.typ = T_J;
                w_dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            default:    w_dec.typ = T_ILL;
        endcase
        w_dec.rd_we = (w_dec.typ inside {T_R, T_I, T_U, T_J}) && (in_instr[11:7] != 5'd0);
    end

    assign w_accept  = in_valid && r_in_ready;
    assign w_illegal = (w_dec.typ == T_ILL);
    assign w_load    = w_accept && (ILLEGAL_PASS || !w_illegal);

    // Buffer occupancy follows (out_valid, skid_valid): EMPTY, ONE, FULL.
    always_comb begin
        w_out_nxt        = r_out;
        w_skid_nxt       = r_skid;
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (r_skid_valid) begin
            if (out_ready) begin
                w_out_nxt        = r_skid;
                w_skid_valid_nxt = 1'b0;
            end
        end else if (r_out_valid) begin
            if (out_ready) begin
                if (w_load) w_out_nxt = w_dec;
                else        w_out_valid_nxt = 1'b0;
            end else if (w_load) begin
                w_skid_nxt       = w_dec;
                w_skid_valid_nxt = 1'b1;
            end
        end else if (w_load) begin
            w_out_nxt       = w_dec;
            w_out_valid_nxt = 1'b1;
        end
    end

    // NOTE: both buffer entries are reset because data outputs must read zero out of reset;
    // state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out           <= '0;
            r_skid          <= '0;
            r_out_valid     <= 1'b0;
            r_skid_valid    <= 1'b0;
            r_in_ready      <= 1'b0;
            r_accept_count  <= '0;
            r_illegal_count <= '0;
        end else begin
            r_out        <= w_out_nxt;
            r_skid       <= w_skid_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            // Registered from next-state skid occupancy, so out_ready never reaches in_ready combinationally.
            r_in_ready   <= !w_skid_valid_nxt;
            if (w_accept && (r_accept_count != {CNT_W{1'b1}}))
                r_accept_count <= r_accept_count + CNT_W'(1);
            if (w_accept && w_illegal && (r_illegal_count != {CNT_W{1'b1}}))
                r_illegal_count <= r_illegal_count + CNT_W'(1);
        end
    end

    always_comb begin
        in_ready      = r_in_ready;
        out_valid     = r_out_valid;
        out_type      = r_out.typ;
        out_opcode    = r_out.instr[6:0];
        out_rd        = r_out.instr[11:7];
        out_rs1       = r_out.instr[19:15];
        out_rs2       = r_out.instr[24:20];
        out_funct3    = r_out.instr[14:12];
        out_funct7    = r_out.instr[31:25];
        out_imm       = r_out.imm;
        out_rd_we     = r_out.rd_we;
        out_instr     = r_out.instr;
        accept_count  = r_accept_count;
        illegal_count = r_illegal_count;
    end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: a reference decoder predicts each accepted word and a
// negedge monitor compares outputs, occupancy-derived in_ready and counters.
module tb_rv_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_type;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_rd_we;
    logic [31:0] out_instr;
    logic [15:0] accept_count;
    logic [15:0] illegal_count;

    // Second instance: 2-bit counters, illegal words dropped.
    logic        b_in_valid;
    logic        b_in_ready;
    logic [31:0] b_in_instr;
    logic        b_out_valid;
    logic        b_out_ready;
    logic [2:0]  b_out_type;
    logic [6:0]  b_out_opcode;
    logic [4:0]  b_out_rd;
    logic [4:0]  b_out_rs1;
    logic [4:0]  b_out_rs2;
    logic [2:0]  b_out_funct3;
    logic [6:0]  b_out_funct7;
    logic [31:0] b_out_imm;
    logic        b_out_rd_we;
    logic [31:0] b_out_instr;
    logic [1:0]  b_accept_count;
    logic [1:0]  b_illegal_count;

    rv_decode_stage #(.CNT_W(16), .ILLEGAL_PASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_rd_we(out_rd_we), .out_instr(out_instr),
        .accept_count(accept_count), .illegal_count(illegal_count)
    );

    rv_decode_stage #(.CNT_W(2), .ILLEGAL_PASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_type(b_out_type),
        .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_funct3(b_out_funct3), .out_funct7(b_out_funct7), .out_imm(b_out_imm),
        .out_rd_we(b_out_rd_we), .out_instr(b_out_instr),
        .accept_count(b_accept_count), .illegal_count(b_illegal_count)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] imm;
        logic        rd_we;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   acc_m  = 0;
    int   ill_m  = 0;
    logic post_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decoder, written with integer arithmetic over the instruction word.
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        int   s;
        int   rd;
        s       = int'(ins);
        rd      = int'(ins[11:7]);
        e.instr = ins;
        e.imm   = 32'd0;
        case (ins[6:0])
            7'h33: e.typ = 3'd0;
            7'h13: begin e.typ = 3'd1; e.imm = s >>> 20; end
            7'h23: begin e.typ = 3'd2; e.imm = (s >>> 25) * 32 + rd; end
            7'h63: begin
                e.typ = 3'd3;
                e.imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048
                        + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            end
            7'h17: begin e.typ = 3'd4; e.imm = ins & 32'hFFFF_F000; end
            7'h6F: begin
                e.typ = 3'd5;
                e.imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096
                        + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
            end
            default: e.typ = 3'd7;
        endcase
        e.rd_we = (e.typ == 3'd0 || e.typ == 3'd1 || e.typ == 3'd4 || e.typ == 3'd5) && (rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [6];
        int          idx;
        ops = '{7'h33, 7'h13, 7'h23, 7'h63, 7'h17, 7'h6F};
        r   = $urandom;
        idx = $urandom_range(0, 7);
        if (idx < 6) r[6:0] = ops[idx];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) post_rst <= 1'b0;
        else        post_rst <= 1'b1;
    end

    // Monitor: compare anything about to transfer, then record anything about to be accepted.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            acc_m = 0;
            ill_m = 0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, post_rst && (sb.size() < 2)});
            check("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            check("accept_count", {16'd0, accept_count}, acc_m);
            check("illegal_count", {16'd0, illegal_count}, ill_m);
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("out_type", {29'd0, out_type}, {29'd0, e.typ});
                check("out_imm", out_imm, e.imm);
                check("out_rd_we", {31'd0, out_rd_we}, {31'd0, e.rd_we});
                check("out_instr", out_instr, e.instr);
                check("out_fields",
                      {out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7},
                      {e.instr[6:0], e.instr[11:7], e.instr[19:15], e.instr[24:20],
                       e.instr[14:12], e.instr[31:25]});
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = ref_decode(in_instr);
                sb.push_back(e);
                if (acc_m < 65535) acc_m++;
                if (e.typ == 3'd7 && ill_m < 65535) ill_m++;
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = ins;
        out_ready = rdy;
    endtask

    task automatic wait_empty();
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int acc_before;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_instr    = 32'd0;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_instr  = 32'd0;
        b_out_ready = 1'b1;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_accept", {16'd0, accept_count}, 32'd0);
        check("rst_illegal", {16'd0, illegal_count}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ADDI x1,x0,-1
        drive(1'b1, 32'hFFF0_0093, 1'b1);
        drive(1'b0, 32'd0, 1'b1);
        wait_empty();

        // SW, BEQ, JAL, AUIPC back-to-back
        drive(1'b1, 32'h0020_A423, 1'b1);
        drive(1'b1, 32'hFE00_0EE3, 1'b1);
        drive(1'b1, 32'h0010_00EF, 1'b1);
        drive(1'b1, 32'h1234_5297, 1'b1);
        drive(1'b0, 32'd0, 1'b1);
        wait_empty();

        // Stall: exactly two accepts, then drain in order
        acc_before = acc_m;
        for (int i = 0; i < 5; i++) drive(1'b1, rand_instr(), 1'b0);
        drive(1'b0, 32'd0, 1'b0);
        @(negedge clk);
        check("stall_accepts", acc_m - acc_before, 2);
        wait_empty();

        // Illegal (load) forwarded with type 7
        drive(1'b1, 32'h0000_0003, 1'b1);
        drive(1'b0, 32'd0, 1'b1);
        wait_empty();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0);
        wait_empty();

        // Fill to FULL, then reset mid-cycle
        for (int i = 0; i < 3; i++) drive(1'b1, rand_instr(), 1'b0);
        drive(1'b0, 32'd0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_accept", {16'd0, accept_count}, 32'd0);
        check("midrst_illegal", {16'd0, illegal_count}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 1'b1);
        drive(1'b1, 32'h0020_A423, 1'b1);
        drive(1'b0, 32'd0, 1'b1);
        wait_empty();

        // Dropping instance with saturating 2-bit counters
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_in_instr = 32'h0000_0003;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        @(negedge clk);
        check("drop_out_valid", {31'd0, b_out_valid}, 32'd0);
        check("drop_accept", {30'd0, b_accept_count}, 32'd1);
        check("drop_illegal", {30'd0, b_illegal_count}, 32'd1);
        check("drop_in_ready", {31'd0, b_in_ready}, 32'd1);
        @(posedge clk);
        #1 b_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("drop_stays_idle", {31'd0, b_out_valid}, 32'd0);
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        check("sat_accept", {30'd0, b_accept_count}, 32'd3);
        check("sat_illegal", {30'd0, b_illegal_count}, 32'd3);
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_in_instr = 32'hFFF0_0093;
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        @(negedge clk);
        check("b_legal_valid", {31'd0, b_out_valid}, 32'd1);
        check("b_legal_type", {29'd0, b_out_type}, 32'd1);
        check("b_legal_imm", b_out_imm, 32'hFFFF_FFFF);
        check("b_sat_accept", {30'd0, b_accept_count}, 32'd3);
        check("b_sat_illegal", {30'd0, b_illegal_count}, 32'd3);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
